// File: rtl/multicycle_control_pkg.sv
// control_pkg: shared definitions for the multi-cycle RV32I controller.
// State enum, opcode constants and the select/operation encodings that the
// datapath (mux selects, ALU, sign-extension unit) agrees on.
// Optional feature macro: MC_ILLEGAL_TRAP_EN adds the TRAP state.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } mc_state_t;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate formats of the sign-extension unit
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B mux
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMMEXT = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Immediate format implied by the opcode; valid in every state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle datapath and its sequencing controller.
// The datapath side (master) supplies instruction fields and status; the
// controller side (slave) returns selects and enables.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       Illegal;

  modport master (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
  );

  modport slave (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: funct3/funct7b5 to ALU operation for R-type and I-type
// arithmetic. Only R-type distinguishes sub via funct7b5; addi never subtracts.
module alu_decoder
  import control_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Select the ALU operation from the funct fields.
  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      3'b000: begin
        if ((op == OP_RTYPE) && funct7b5) alu_control = ALU_SUB;
        else                               alu_control = ALU_ADD;
      end
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencing FSM for the multi-cycle RV32I datapath.
// Fetch/memory states wait on MemReady. Outputs are combinational from the
// state (plus Zero, MemReady and the decode fields); rst gates all enables.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (unknown opcodes park in TRAP).
module multicycle_control
  import control_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_control_if.slave ctl
);

  // op, funct3 and funct7b5 are taken from fixed bit positions up to Instr[30].
  if (INSTRUCTION_WIDTH < 31) begin : g_width_check
    $error("multicycle_control: INSTRUCTION_WIDTH too small for funct7b5");
  end

  mc_state_t  state_r;
  mc_state_t  next_state_s;
  logic [2:0] alu_dec_s;

  logic       pc_write_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [2:0] alu_control_s;
  logic [1:0] imm_src_s;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_s;
`endif

  alu_decoder u_alu_decoder (
    .op          (ctl.op),
    .funct3      (ctl.funct3),
    .funct7b5    (ctl.funct7b5),
    .alu_control (alu_dec_s)
  );

  // State register; reset returns the sequencer to FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= next_state_s;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    next_state_s  = state_r;
    pc_write_s    = 1'b0;
    adr_src_s     = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    result_src_s  = RES_ALUOUT;
    alu_src_a_s   = SRCA_PC;
    alu_src_b_s   = SRCB_RS2;
    alu_control_s = ALU_ADD;
    imm_src_s     = imm_src_of(ctl.op);
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_s     = 1'b0;
`endif
    case (state_r)
      S_FETCH: begin
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        ir_write_s   = ctl.MemReady;
        pc_write_s   = ctl.MemReady;
        if (ctl.MemReady) next_state_s = S_DECODE;
        else              next_state_s = S_FETCH;
      end
      S_DECODE: begin
        // Branch target OldPC + imm lands in ALUOut for BEQ.
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMMEXT;
        case (ctl.op)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECUTER;
          OP_ITYPE:          next_state_s = S_EXECUTEI;
          OP_BRANCH:         next_state_s = S_BEQ;
          OP_JAL:            next_state_s = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           next_state_s = S_TRAP;
`else
          default:           next_state_s = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMMEXT;
        if (ctl.op == OP_LOAD) next_state_s = S_MEMREAD;
        else                   next_state_s = S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_s    = 1'b1;
        result_src_s = RES_ALUOUT;
        if (ctl.MemReady) next_state_s = S_MEMWB;
        else              next_state_s = S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s    = 1'b1;
        result_src_s = RES_ALUOUT;
        mem_write_s  = 1'b1;
        if (ctl.MemReady) next_state_s = S_FETCH;
        else              next_state_s = S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a_s   = SRCA_RS1;
        alu_src_b_s   = SRCB_RS2;
        alu_control_s = alu_dec_s;
        next_state_s  = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_s   = SRCA_RS1;
        alu_src_b_s   = SRCB_IMMEXT;
        alu_control_s = alu_dec_s;
        next_state_s  = S_ALUWB;
      end
      S_ALUWB: begin
        result_src_s = RES_ALUOUT;
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_s   = SRCA_RS1;
        alu_src_b_s   = SRCB_RS2;
        alu_control_s = ALU_SUB;
        result_src_s  = RES_ALUOUT;
        pc_write_s    = ctl.Zero;
        next_state_s  = S_FETCH;
      end
      S_JAL: begin
        // PC <- branch target in ALUOut; ALU forms OldPC + 4 for the link.
        alu_src_a_s  = SRCA_OLDPC;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALUOUT;
        pc_write_s   = 1'b1;
        next_state_s = S_ALUWB;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_s    = 1'b1;
        next_state_s = S_TRAP;
      end
`endif
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Reset cycle must never commit a write, so every enable is gated by rst.
  assign ctl.PCWrite    = pc_write_s  & ~rst;
  assign ctl.IRWrite    = ir_write_s  & ~rst;
  assign ctl.MemWrite   = mem_write_s & ~rst;
  assign ctl.RegWrite   = reg_write_s & ~rst;
  assign ctl.AdrSrc     = adr_src_s;
  assign ctl.ResultSrc  = result_src_s;
  assign ctl.ALUSrcA    = alu_src_a_s;
  assign ctl.ALUSrcB    = alu_src_b_s;
  assign ctl.ALUControl = alu_control_s;
  assign ctl.ImmSrc     = imm_src_s;
`ifdef MC_ILLEGAL_TRAP_EN
  assign ctl.Illegal    = illegal_s & ~rst;
`else
  assign ctl.Illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A phase-list reference model
// describes each instruction as a sequence of named steps and derives the
// expected control word per cycle from the per-step output table.
module tb_multicycle_control;

  typedef string str_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.INSTRUCTION_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal}
  logic [16:0] obs_w;
  assign obs_w = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                  bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                  bus.ImmSrc, bus.Illegal};

  // Steps an instruction walks through, by opcode.
  function automatic str_q_t phases(input logic [6:0] op);
    str_q_t q;
    q = {"FETCH", "DECODE"};
    case (op)
      7'b0000011: q = {q, "MEMADR", "MEMREAD", "MEMWB"};
      7'b0100011: q = {q, "MEMADR", "MEMWRITE"};
      7'b0110011: q = {q, "EXECUTER", "ALUWB"};
      7'b0010011: q = {q, "EXECUTEI", "ALUWB"};
      7'b1100011: q = {q, "BEQ"};
      7'b1101111: q = {q, "JAL", "ALUWB"};
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        q = {q, "TRAP"};
`endif
      end
    endcase
    return q;
  endfunction

  // Expected control word for one cycle of a named step.
  function automatic logic [16:0] model(input string ph, input logic [6:0] op,
      input logic [2:0] f3, input logic f7, input logic z, input logic mr, input logic r);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, a, b, imm;
    logic [2:0] alu, dec;
    pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
    res = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
    case (f3)
      3'b000:  dec = (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  dec = 3'b101;
      3'b110:  dec = 3'b011;
      3'b111:  dec = 3'b010;
      default: dec = 3'b000;
    endcase
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (ph)
      "FETCH":    begin b = 2'b10; res = 2'b10; pcw = mr; irw = mr; end
      "DECODE":   begin a = 2'b01; b = 2'b01; end
      "MEMADR":   begin a = 2'b10; b = 2'b01; end
      "MEMREAD":  begin adr = 1'b1; end
      "MEMWB":    begin res = 2'b01; rw = 1'b1; end
      "MEMWRITE": begin adr = 1'b1; mw = 1'b1; end
      "EXECUTER": begin a = 2'b10; b = 2'b00; alu = dec; end
      "EXECUTEI": begin a = 2'b10; b = 2'b01; alu = dec; end
      "ALUWB":    begin rw = 1'b1; end
      "BEQ":      begin a = 2'b10; alu = 3'b001; pcw = z; end
      "JAL":      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      "TRAP":     begin ill = 1'b1; end
      default:    begin end
    endcase
    if (r) begin pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; ill = 1'b0; end
    return {pcw, adr, mw, irw, rw, res, a, b, alu, imm, ill};
  endfunction

  // Runs one instruction cycle by cycle, comparing every cycle's control word.
  // mem_stalls forces that many MemReady=0 cycles in MEMREAD/MEMWRITE;
  // abort_at asserts rst in the first cycle of that step and ends the instruction.
  task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
      input logic z, input bit rnd, input int mem_stalls, input int abort_at,
      output int mw_cnt, output int rw_cnt, output int pcw_cnt);
    str_q_t ph;
    logic [16:0] exp;
    logic mr;
    bit aborted;
    ph = phases(op);
    mw_cnt = 0; rw_cnt = 0; pcw_cnt = 0; aborted = 1'b0;
    for (int i = 0; i < ph.size(); i++) begin
      int stalls;
      bit done;
      stalls = 0; done = 1'b0;
      while (!done) begin
        @(negedge clk);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
        rst = (i == abort_at);
        if (ph[i] == "MEMREAD" || ph[i] == "MEMWRITE")
          mr = (stalls < mem_stalls) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
        else if (ph[i] == "FETCH")
          mr = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        else
          mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.MemReady = mr;
        #1;
        exp = model(ph[i], op, f3, f7, z, mr, rst);
        tests_run++;
        if (obs_w !== exp) begin
          tests_failed++;
          $display("FAIL ctl_word step=%s op=%b f3=%b f7=%b z=%b mr=%b rst=%b: got %b expected %b",
                   ph[i], op, f3, f7, z, mr, rst, obs_w, exp);
        end
        if (bus.MemWrite === 1'b1) mw_cnt++;
        if (bus.RegWrite === 1'b1) rw_cnt++;
        if (bus.PCWrite === 1'b1) pcw_cnt++;
        if (i == abort_at) begin
          aborted = 1'b1; done = 1'b1;
        end else if ((ph[i] == "FETCH" || ph[i] == "MEMREAD" || ph[i] == "MEMWRITE") && !mr) begin
          stalls++;
        end else begin
          done = 1'b1;
        end
      end
      if (aborted) break;
    end
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    @(negedge clk);
    rst = 1'b1; bus.op = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b1; bus.MemReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      exp = model("FETCH", 7'b0000011, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
      tests_run++;
      if (obs_w !== exp) begin
        tests_failed++;
        $display("FAIL reset_state: got %b expected %b", obs_w, exp);
      end
    end
  endtask

  task automatic test_lw();
    int mw, rw, pcw;
    exec_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, -1, mw, rw, pcw);
    tests_run++;
    if (rw !== 1 || mw !== 0) begin
      tests_failed++;
      $display("FAIL lw_writes: got regwrite=%0d memwrite=%0d expected 1 and 0", rw, mw);
    end
  endtask

  task automatic test_sw_stall();
    int mw, rw, pcw;
    exec_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 3, -1, mw, rw, pcw);
    tests_run++;
    if (mw !== 4 || rw !== 0) begin
      tests_failed++;
      $display("FAIL sw_stall: got memwrite=%0d regwrite=%0d expected 4 and 0", mw, rw);
    end
  endtask

  task automatic test_alu_decode();
    int mw, rw, pcw;
    exec_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 0, -1, mw, rw, pcw); // sub
    exec_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, -1, mw, rw, pcw); // add
    exec_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 0, -1, mw, rw, pcw); // addi
    exec_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 0, -1, mw, rw, pcw); // slt
    exec_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0, 0, -1, mw, rw, pcw); // ori
    exec_instr(7'b0110011, 3'b111, 1'b1, 1'b0, 1'b0, 0, -1, mw, rw, pcw); // and
    exec_instr(7'b0010011, 3'b001, 1'b0, 1'b0, 1'b0, 0, -1, mw, rw, pcw); // other -> add
  endtask

  task automatic test_beq();
    int mw, rw, pcw;
    exec_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0, -1, mw, rw, pcw);
    tests_run++;
    if (pcw !== 2) begin
      tests_failed++;
      $display("FAIL beq_taken_pcwrite: got %0d cycles expected 2", pcw);
    end
    exec_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 0, -1, mw, rw, pcw);
    tests_run++;
    if (pcw !== 1) begin
      tests_failed++;
      $display("FAIL beq_not_taken_pcwrite: got %0d cycles expected 1", pcw);
    end
  endtask

  task automatic test_jal_reset();
    int mw, rw, pcw;
    exec_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0, -1, mw, rw, pcw);
    tests_run++;
    if (rw !== 1 || pcw !== 2) begin
      tests_failed++;
      $display("FAIL jal_enables: got regwrite=%0d pcwrite=%0d expected 1 and 2", rw, pcw);
    end
    // Abort in ALUWB (step index 3): RegWrite must stay low.
    exec_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 3, mw, rw, pcw);
    tests_run++;
    if (rw !== 0) begin
      tests_failed++;
      $display("FAIL jal_abort_regwrite: got %0d expected 0", rw);
    end
    // Next instruction starts in FETCH (checked per cycle).
    exec_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 0, -1, mw, rw, pcw);
  endtask

  task automatic test_illegal();
    int mw, rw, pcw;
    exec_instr(7'b1111111, 3'b000, 1'b0, 1'b1, 1'b0, 0, -1, mw, rw, pcw);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      logic [16:0] exp;
      @(negedge clk);
      bus.MemReady = 1'($urandom_range(0, 1));
      #1;
      exp = model("TRAP", 7'b1111111, 3'b000, 1'b0, 1'b1, bus.MemReady, 1'b0);
      tests_run++;
      if (obs_w !== exp) begin
        tests_failed++;
        $display("FAIL trap_hold: got %b expected %b", obs_w, exp);
      end
    end
    @(negedge clk);
    rst = 1'b1;
`endif
    // Without the trap this lands straight back in FETCH with Illegal=0.
    exec_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 0, -1, mw, rw, pcw);
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    int mw, rw, pcw;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    for (int n = 0; n < 60; n++) begin
      exec_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                 int'($urandom_range(0, 2)), -1, mw, rw, pcw);
    end
  endtask

  initial begin
    bus.op = 7'b0000000; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.MemReady = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_alu_decode();
    test_beq();
    test_jal_reset();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle RV32I datapath. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback. Per state it drives the datapath mux selects, the write enables, the ALU operation and the `ImmSrc` select of the sign-extension unit. Memory states stall on a ready handshake so the same controller works with single-cycle and multi-cycle memories.

## Interface
Parameters:
- `INSTRUCTION_WIDTH`, 32: width of the instruction register feeding the opcode and funct fields.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 7: `Instr[6:0]`.
- `funct3` in 3: `Instr[14:12]`.
- `funct7b5` in 1: `Instr[30]`.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory has completed the current access this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = result.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register and OldPC enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select; 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` out 2: ALU B select; 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ALUControl` out 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` out 2: immediate format; 00 I, 01 S, 10 B, 11 J.
- `Illegal` out 1: unsupported opcode trap flag.

## Operation
States and transitions:
- FETCH: outputs AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite both equal MemReady.
  - Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE: outputs ALUSrcA=01, ALUSrcB=01, add; this forms the branch target in ALUOut.
  - Next state by opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECUTER.
  - 0010011 → EXECUTEI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - Any other opcode → TRAP with `MC_ILLEGAL_TRAP_EN` defined, else FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Holds with MemWrite asserted until MemReady=1, then goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU decoded from funct fields. Next is ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU decoded from funct fields. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero. Next is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next is ALUWB, which writes OldPC+4 to rd.

Signals not listed for a state are 0, and `ALUControl` defaults to add.

ALU decode (EXECUTER and EXECUTEI only), by funct3:
- 000: sub if op=0110011 and funct7b5=1, else add.
- 010: slt.
- 110: or.
- 111: and.
- Any other funct3: add.

ImmSrc decode, combinational from `op` in every state:
- 0100011 → 01.
- 1100011 → 10.
- 1101111 → 11.
- All other opcodes → 00.

## Timing
- Reset: state := FETCH on the first rising edge with rst=1. While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0.
- Reset asserted mid-instruction aborts it. No write enable is asserted in the reset cycle, and no partial write occurs.
- Cycle counts with MemReady held at 1:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
- Each cycle MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay constant across stall cycles.
- MemReady is ignored in every other state.
- Outputs are pure functions of the state, plus Zero (BEQ), MemReady (FETCH), and op/funct (ALU and ImmSrc decode). There are no output registers.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE enters TRAP.
  - In TRAP, `Illegal`=1, all enables are 0, and the state is held until reset.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - The TRAP state is not compiled.
  - An unknown opcode returns to FETCH, so the instruction acts as a nop with PC already advanced by 4.
  - `Illegal` is tied to 0.

## Structure
- `control_pkg` holds:
  - The state enum `mc_state_t`.
  - Opcode constants (`OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_ITYPE`, `OP_BRANCH`, `OP_JAL`).
  - ALUControl encodings.
  - ImmSrc encodings shared with the sign-extension unit.
  - ResultSrc, ALUSrcA and ALUSrcB encodings.
- Sub-module `alu_decoder` maps (op, funct3, funct7b5) to ALUControl. It is instantiated once, and its result is used only in the EXECUTER and EXECUTEI states.

## Test plan
- Reset, then `lw` (op=0000011), MemReady=1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. RegWrite=1 and ResultSrc=01 only in cycle 5. ImmSrc=00.
- `sw` (op=0100011) with MemReady low for 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, ImmSrc=01, RegWrite never asserted.
- `sub` (op=0110011, funct3=000, funct7b5=1) → ALUControl=001 in EXECUTER. With funct7b5=0 → 000. `addi` with funct7b5=1 → 000.
- `beq` (op=1100011) with Zero=1 → PCWrite=1 in cycle 3, ImmSrc=10. With Zero=0 → PCWrite=0 and next state is FETCH.
- `jal` (op=1101111) → PCWrite in JAL, RegWrite with ResultSrc=00 in ALUWB, ImmSrc=11. Then assert rst in the ALUWB cycle → RegWrite=0 that cycle and state is FETCH next.
- op=1111111:
  - With `MC_ILLEGAL_TRAP_EN` → Illegal=1 from cycle 3 onward and all enables 0.
  - Without it → back in FETCH in cycle 3 and Illegal=0.
